multiplier_2x3: RTL and testbench

- Unsigned 2-bit × 3-bit multiplier producing a 5-bit product.
- Built as a gate-level array: AND-gate partial products feeding a half-adder / full-adder reduction chain.
- The product is captured in an output register with a valid flag.
- Leaf arithmetic block; instantiated wherever a small constant-width product is needed.

---
 rtl/multiplier_2x3.sv | 86 ++++++++
 tb/tb_multiplier_2x3.sv | 139 +++++++++++++
 2 files changed

// File: rtl/multiplier_2x3.sv
// multiplier_2x3: unsigned 2-bit x 3-bit array multiplier with a 5-bit product.
// AND-gate partial products feed a half-adder / full-adder chain. By default
// the product and a valid flag are registered, giving 1-cycle latency and
// asynchronous reset values.
// Build option: define MULT_COMB_OUT_EN to bypass the output register. p and
// out_valid then follow the inputs combinationally, and clock/reset have no effect.
module multiplier_2x3 (
   input  logic       clock,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [1:0] m,
   input  logic [2:0] q,
   output logic [4:0] p,
   output logic       out_valid
);

   // Partial product matrix: w_pp[i][j] = m[i] & q[j]
   logic [1:0][2:0] w_pp;

   genvar gi, gj;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_row
         for (gj = 0; gj < 3; gj++) begin : g_col
            assign w_pp[gi][gj] = m[gi] & q[gj];
         end
      end
   endgenerate

   // Reduction chain sums and carries
   logic w_s1, w_c1;
   logic w_s2, w_c2;
   logic w_s3, w_c3;
   logic [4:0] w_prod;

   // HA1: weight-1 column
   assign w_s1 = w_pp[1][0] ^ w_pp[0][1];
   assign w_c1 = w_pp[1][0] & w_pp[0][1];

   // FA2: weight-2 column, absorbing the carry from HA1
   assign w_s2 = w_pp[1][1] ^ w_pp[0][2] ^ w_c1;
   assign w_c2 = (w_pp[1][1] & w_pp[0][2]) |
                 (w_pp[1][1] & w_c1)       |
                 (w_pp[0][2] & w_c1);

   // HA3: weight-3 column; its carry becomes the product MSB
   assign w_s3 = w_pp[1][2] ^ w_c2;
   assign w_c3 = w_pp[1][2] & w_c2;

   // The maximum result is 3*7 = 21, so 5 bits never overflow
   assign w_prod = {w_c3, w_s3, w_s2, w_s1, w_pp[0][0]};

`ifdef MULT_COMB_OUT_EN

   // Clock and reset are kept as ports for drop-in compatibility only
   logic w_unused;
   assign w_unused = clock | reset;

   // Zero-latency path: the output follows the array directly
   assign p         = w_prod;
   assign out_valid = in_valid;

`else

   logic [4:0] r_p;
   logic       r_valid;

   // Capture the product when in_valid is high, otherwise hold it. Valid is a
   // one-cycle pulse per accepted operand pair.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_p     <= 5'b00000;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_p <= w_prod;
         end
      end
   end

   assign p         = r_p;
   assign out_valid = r_valid;

`endif

endmodule

// File: tb/tb_multiplier_2x3.sv
// Directed testbench for multiplier_2x3 in its default, registered build.
// Expected products are pushed to a scoreboard queue when operands are driven.
// They are popped and compared when out_valid is seen.
module tb_multiplier_2x3;

   logic       clock;
   logic       reset;
   logic       in_valid;
   logic [1:0] m;
   logic [2:0] q;
   logic [4:0] p;
   logic       out_valid;

   int         checks;
   int         errors;
   logic [4:0] sb_q[$];
   logic [4:0] last_p;

   multiplier_2x3 dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .m         (m),
      .q         (q),
      .p         (p),
      .out_valid (out_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Called 1 time unit after a rising edge. The task drives the operands,
   // waits for the next edge, and then checks the response.
   task automatic step(input logic v, input logic [1:0] mi, input logic [2:0] qi);
      logic [4:0] exp_p;
      in_valid = v;
      m        = mi;
      q        = qi;
      if (v) sb_q.push_back(5'(mi) * 5'(qi));
      @(posedge clock);
      #1;
      chk($sformatf("valid m=%0d q=%0d", mi, qi), {4'b0, out_valid}, {4'b0, v});
      if (out_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("scoreboard_underflow", 5'd1, 5'd0);
         end else begin
            exp_p = sb_q.pop_front();
            chk($sformatf("prod m=%0d q=%0d", mi, qi), p, exp_p);
            last_p = exp_p;
         end
      end else begin
         chk($sformatf("hold m=%0d q=%0d", mi, qi), p, last_p);
      end
      $display("txn v=%0b m=%0d q=%0d -> out_valid=%0b p=%0d", v, mi, qi, out_valid, p);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      last_p   = 5'd0;
      in_valid = 1'b0;
      m        = 2'd0;
      q        = 3'd0;
      reset    = 1'b1;
      #1;
      chk("reset_p", p, 5'd0);
      chk("reset_valid", {4'b0, out_valid}, 5'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Zero operands still give a valid result
      step(1'b1, 2'b00, 3'b000);
      step(1'b1, 2'b01, 3'b000);
      // Small products
      step(1'b1, 2'b01, 3'b001);
      step(1'b1, 2'b01, 3'b110);
      step(1'b1, 2'b10, 3'b101);
      step(1'b1, 2'b10, 3'b110);
      // Carry chain through to the MSB
      step(1'b1, 2'b11, 3'b011);
      step(1'b1, 2'b11, 3'b110);
      step(1'b1, 2'b11, 3'b111);
      // Idle cycle: the product holds and valid drops
      step(1'b0, 2'b10, 3'b010);

      // Assert reset mid-cycle with p = 21; it must clear p with no clock edge
      chk("pre_reset_p", p, 5'b10101);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_p", p, 5'd0);
      chk("async_reset_valid", {4'b0, out_valid}, 5'd0);
      sb_q.delete();
      last_p = 5'd0;
      // Inputs must be ignored while reset is high
      in_valid = 1'b1;
      m        = 2'b11;
      q        = 3'b111;
      @(posedge clock);
      #1;
      chk("reset_held_p", p, 5'd0);
      chk("reset_held_valid", {4'b0, out_valid}, 5'd0);
      reset = 1'b0;
      step(1'b0, 2'b11, 3'b111);
      step(1'b0, 2'b11, 3'b111);

      // Stream all 32 operand pairs back to back
      for (int mi = 0; mi < 4; mi++) begin
         for (int qi = 0; qi < 8; qi++) begin
            step(1'b1, 2'(mi), 3'(qi));
         end
      end
      step(1'b0, 2'b01, 3'b010);
      step(1'b0, 2'b00, 3'b001);
      chk("stream_hold_last", p, 5'd21);
      chk("scoreboard_empty", 5'(sb_q.size()), 5'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Bound the run in case the clock or the bench stalls
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
